ddr_tx_arbiter: RTL and testbench

Shares the single 16-bit transmit word path (UART serializer with a tx_ready handshake) between two packet sources.
- src0: the game-state frame stream (pause/next, score, status, arrows).
- src1: the low-latency event stream (key hits, acks).

The block locks the grant for a whole packet, so packets are never interleaved. src1 has priority, with bounded starvation of src0. Output is registered, and the block sits directly in front of the serializer.

---
 rtl/ddr_tx_arbiter_pkg.sv | 17 +
 rtl/ddr_tx_outreg.sv | 32 +++
 rtl/ddr_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_ddr_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_tx_arbiter_pkg.sv
// Shared definitions for the transmit-path arbiter: word width, abort marker,
// FSM encodings and default burst/timeout limits.
package ddr_tx_arbiter_pkg;

  localparam int DDR_WORD_W    = 16;
  localparam int DDR_MAX_BURST = 4;
  localparam int DDR_TIMEOUT   = 1024;
  localparam logic [DDR_WORD_W-1:0] DDR_ABORT_WORD = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } state_e;

endpackage

// File: rtl/ddr_tx_outreg.sv
// Single-entry registered output stage with valid/ready bookkeeping.
// slot_free tells upstream that a new word may be loaded this cycle.
module ddr_tx_outreg #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [WORD_W-1:0] tx_data,
  output logic              slot_free
);

  // Handshake: a word moves to the serializer on a clock edge where
  // tx_valid & tx_ready; load must only be asserted while slot_free.
  assign slot_free = !tx_valid || tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_data;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr_tx_arbiter.sv
// Packet-locked two-source arbiter in front of the tx serializer; src1 wins
// with bounded starvation of src0. Optional stall watchdog: DDR_TX_WATCHDOG_EN.
module ddr_tx_arbiter
  import ddr_tx_arbiter_pkg::*;
#(
  parameter int WORD_W    = DDR_WORD_W,
  parameter int MAX_BURST = DDR_MAX_BURST,
  parameter int TIMEOUT   = DDR_TIMEOUT,
  parameter logic [WORD_W-1:0] ABORT_WORD = DDR_ABORT_WORD,
  localparam int SW = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src0_valid,
  input  logic [WORD_W-1:0] src0_data,
  input  logic              src0_last,
  output logic              src0_ready,
  input  logic              src1_valid,
  input  logic [WORD_W-1:0] src1_data,
  input  logic              src1_last,
  output logic              src1_ready,
  output logic [WORD_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_pulse,
  output state_e            state,
  output logic [SW-1:0]     starve_cnt
);

  if (MAX_BURST < 1 || TIMEOUT < 2) begin : g_param_check
    $error("ddr_tx_arbiter: MAX_BURST must be >= 1 and TIMEOUT >= 2");
  end

  logic              slot_free;
  logic              acc0, acc1;
  logic              abort_load;
  logic              stall_hit;
  logic              load;
  logic [WORD_W-1:0] load_data;
  logic              starve_full;

  assign src0_ready  = (state == GNT0) && slot_free;
  assign src1_ready  = (state == GNT1) && slot_free;
  assign acc0        = src0_valid && src0_ready;
  assign acc1        = src1_valid && src1_ready;
  assign starve_full = (starve_cnt == SW'(MAX_BURST));

  assign load      = acc0 || acc1 || abort_load;
  assign load_data = abort_load ? ABORT_WORD : (acc1 ? src1_data : src0_data);
  assign busy      = (state != IDLE) || tx_valid;

  ddr_tx_outreg #(.WORD_W(WORD_W)) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .slot_free (slot_free)
  );

`ifdef DDR_TX_WATCHDOG_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_cnt;
  logic               owner_valid;

  assign owner_valid = (state == GNT0) ? src0_valid : src1_valid;
  assign stall_hit   = ((state == GNT0) || (state == GNT1)) && !owner_valid &&
                       (stall_cnt == STALL_W'(TIMEOUT - 1));
  assign abort_load  = (state == ABORT) && slot_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt     <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= abort_load;
      if ((state != GNT0 && state != GNT1) || acc0 || acc1 || stall_hit) begin
        stall_cnt <= '0;
      end else if (!owner_valid) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`else
  assign stall_hit     = 1'b0;
  assign abort_load    = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // src0 is forced in once it has watched MAX_BURST src1 packets go by.
          if (src1_valid && !(src0_valid && starve_full)) begin
            state <= GNT1;
            grant <= 2'b10;
            if (src0_valid) starve_cnt <= starve_cnt + 1'b1;
          end else if (src0_valid) begin
            state      <= GNT0;
            grant      <= 2'b01;
            starve_cnt <= '0;
          end
        end
        GNT0: begin
          if (acc0 && src0_last) begin
            state <= IDLE;
            grant <= 2'b00;
          end else if (stall_hit) begin
            state <= ABORT;
            grant <= 2'b00;
          end
        end
        GNT1: begin
          if (acc1 && src1_last) begin
            state <= IDLE;
            grant <= 2'b00;
          end else if (stall_hit) begin
            state <= ABORT;
            grant <= 2'b00;
          end
        end
`ifdef DDR_TX_WATCHDOG_EN
        ABORT: begin
          if (slot_free) state <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_tx_arbiter.sv
// Directed bench for ddr_tx_arbiter (MAX_BURST=2, TIMEOUT=8); the watchdog
// scenario runs only when DDR_TX_WATCHDOG_EN is defined.
module tb_ddr_tx_arbiter;
  import ddr_tx_arbiter_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         src0_valid, src0_last, src0_ready;
  logic [W-1:0] src0_data;
  logic         src1_valid, src1_last, src1_ready;
  logic [W-1:0] src1_data;
  logic [W-1:0] tx_data;
  logic         tx_valid, tx_ready;
  logic [1:0]   grant;
  logic         busy, timeout_pulse;
  state_e       state;
  logic [1:0]   starve_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  ddr_tx_arbiter #(.WORD_W(W), .MAX_BURST(2), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .src0_valid    (src0_valid),
    .src0_data     (src0_data),
    .src0_last     (src0_last),
    .src0_ready    (src0_ready),
    .src1_valid    (src1_valid),
    .src1_data     (src1_data),
    .src1_last     (src1_last),
    .src1_ready    (src1_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .grant         (grant),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .state         (state),
    .starve_cnt    (starve_cnt)
  );

  // clock / time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor: capture words the serializer takes, plus timeout pulses
  always @(negedge clk) begin
    if (!rst) begin
      check("one_ready", {31'b0, src0_ready & src1_ready}, 32'd0);
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (timeout_pulse) begin
        pulse_cnt++;
        check("pulse_word", {15'b0, tx_valid, tx_data}, {15'b0, 1'b1, 16'hDEAD});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic mark_last);
    logic [W-1:0] w[3];
    logic acc;
    int t;
    w[0] = a; w[1] = b; w[2] = c;
    for (int i = 0; i < n; i++) begin
      src0_valid = 1'b1;
      src0_data  = w[i];
      src0_last  = mark_last && (i == n - 1);
      t = 0;
      do begin
        @(negedge clk);
        acc = src0_valid & src0_ready;
        step();
        t++;
      end while (!acc && t < 200);
      check("src0_handshake", {31'b0, acc}, 32'd1);
    end
    src0_valid = 1'b0;
    src0_last  = 1'b0;
  endtask

  task automatic send1(input logic [W-1:0] a);
    logic acc;
    int t;
    src1_valid = 1'b1;
    src1_data  = a;
    src1_last  = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      acc = src1_valid & src1_ready;
      step();
      t++;
    end while (!acc && t < 200);
    check("src1_handshake", {31'b0, acc}, 32'd1);
    src1_valid = 1'b0;
    src1_last  = 1'b0;
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, {16'b0, got_q[i]}, {16'b0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; tx_ready = 1'b1;
    src0_valid = 1'b0; src0_data = '0; src0_last = 1'b0;
    src1_valid = 1'b0; src1_data = '0; src1_last = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_data", {16'b0, tx_data}, 32'd0);
    check("rst_grant", {30'b0, grant}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {30'b0, src1_ready, src0_ready}, 32'd0);
    check("rst_state", {30'b0, state}, {30'b0, IDLE});
    check("rst_starve", {30'b0, starve_cnt}, 32'd0);
    check("rst_pulse", {31'b0, timeout_pulse}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Test 1: single src0 packet, cycle by cycle
    src0_valid = 1'b1; src0_data = 16'h0001; src0_last = 1'b0;
    @(negedge clk);
    check("t1_grant_c0", {30'b0, grant}, 32'd0);
    check("t1_ready_c0", {31'b0, src0_ready}, 32'd0);
    step();
    @(negedge clk);
    check("t1_grant_c1", {30'b0, grant}, 32'h1);
    check("t1_ready_c1", {31'b0, src0_ready}, 32'd1);
    check("t1_txv_c1", {31'b0, tx_valid}, 32'd0);
    step();
    src0_data = 16'h00AA;
    @(negedge clk);
    check("t1_tx_c2", {15'b0, tx_valid, tx_data}, {15'b0, 1'b1, 16'h0001});
    step();
    src0_data = 16'h0096; src0_last = 1'b1;
    @(negedge clk);
    check("t1_tx_c3", {15'b0, tx_valid, tx_data}, {15'b0, 1'b1, 16'h00AA});
    step();
    src0_valid = 1'b0; src0_last = 1'b0;
    @(negedge clk);
    check("t1_tx_c4", {15'b0, tx_valid, tx_data}, {15'b0, 1'b1, 16'h0096});
    check("t1_grant_c4", {30'b0, grant}, 32'd0);
    check("t1_busy_c4", {31'b0, busy}, 32'd1);
    step();
    @(negedge clk);
    check("t1_busy_c5", {31'b0, busy}, 32'd0);
    check("t1_txv_c5", {31'b0, tx_valid}, 32'd0);
    exp_q = '{16'h0001, 16'h00AA, 16'h0096};
    compare_stream("t1");
    step();

    // Test 2: simultaneous request, src1 first, no interleave
    fork
      send0(3, 16'h0001, 16'h00AA, 16'h0096, 1'b1);
      send1(16'h0501);
    join
    repeat (3) step();
    exp_q = '{16'h0501, 16'h0001, 16'h00AA, 16'h0096};
    compare_stream("t2");
    check("t2_starve", {30'b0, starve_cnt}, 32'd0);

    // Test 3: src1 bursts, src0 forced in after MAX_BURST=2
    fork
      send0(1, 16'h0C0C, 16'h0, 16'h0, 1'b1);
      begin
        send1(16'h1001);
        send1(16'h1002);
        send1(16'h1003);
      end
    join
    repeat (3) step();
    exp_q = '{16'h1001, 16'h1002, 16'h0C0C, 16'h1003};
    compare_stream("t3");
    check("t3_starve", {30'b0, starve_cnt}, 32'd0);

    // Test 4: 5 cycles of backpressure while the 2nd word is on the output
    fork
      send0(3, 16'h4001, 16'h4002, 16'h4003, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("t4_hold", {15'b0, tx_valid, tx_data}, {15'b0, 1'b1, 16'h4002});
          check("t4_ready", {31'b0, src0_ready}, 32'd0);
        end
        step();
        tx_ready = 1'b1;
      end
    join
    repeat (3) step();
    exp_q = '{16'h4001, 16'h4002, 16'h4003};
    compare_stream("t4");

    // Test 5: reset mid-packet, then a fresh request
    src0_valid = 1'b1; src0_data = 16'h5001; src0_last = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; src0_valid = 1'b0;
    @(negedge clk);
    check("t5_txv", {31'b0, tx_valid}, 32'd0);
    check("t5_txd", {16'b0, tx_data}, 32'd0);
    check("t5_grant", {30'b0, grant}, 32'd0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    step();
    send1(16'h5A5A);
    repeat (3) step();
    exp_q = '{16'h5A5A};
    compare_stream("t5");

`ifdef DDR_TX_WATCHDOG_EN
    // Test 6: src0 stalls mid-packet, watchdog aborts, pending src1 served
    send0(1, 16'h6001, 16'h0, 16'h0, 1'b0);
    send1(16'h6100);
    repeat (3) step();
    exp_q = '{16'h6001, 16'hDEAD, 16'h6100};
    compare_stream("t6");
    check("t6_pulse_cnt", pulse_cnt, 32'd1);
`else
    check("no_wd_pulse_cnt", pulse_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
